// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle ops (ADD, SUB, AND, OR, NOR, NOP,
// SRL, SLT, XOR, SLTi, reserved) complete one cycle after the start edge.
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle for 32
// cycles and complete 33 cycles after the start edge.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start_in     request strobe, sampled only when idle
//   alu_ctrl_in  [3:0] operation code
//   a_in, b_in   [31:0] operands (b_in[4:0] = SRL shift amount)
//   result_out   [31:0] result of last completed op
//   zero_out     result_out == 0 (registered)
//   hi_out       [31:0] MUL upper word / DIV remainder
//   busy_out     iterative op in progress
//   done_out     one-cycle pulse when result_out updates
//   div0_out     last completed op was DIV by zero
//
// Build option: define ALU_SEQ_HI_LO_EN to enable the hi_out register.
// Without it hi_out is tied to 0.
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic [3:0]  alu_ctrl_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] result_out,
  output logic        zero_out,
  output logic [31:0] hi_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        div0_out
);

  typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_a;      // multiplicand (MUL) or divisor (DIV)
  logic [31:0] r_hi;     // partial product upper word / partial remainder
  logic [31:0] r_lo;     // multiplier bits / dividend-quotient bits
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_done;
  logic        r_div0;

  logic [31:0] w_alu;
  logic        w_last;
  logic [32:0] w_sum;
  logic [31:0] w_mhi, w_mlo;
  logic [32:0] w_rsh;
  logic        w_ge;
  logic [31:0] w_rsub, w_dhi, w_dlo;

  // Single-cycle operations
  always_comb begin
    w_alu = '0;
    case (alu_ctrl_in)
      4'b0000: w_alu = a_in + b_in;
      4'b0001: w_alu = a_in - b_in;
      4'b0100: w_alu = a_in & b_in;
      4'b0101: w_alu = a_in | b_in;
      4'b0110: w_alu = ~(a_in | b_in);
      4'b1000: w_alu = a_in >> b_in[4:0];
      4'b1001,
      4'b1011: w_alu = {31'd0, $signed(a_in) < $signed(b_in)};
      4'b1010: w_alu = a_in ^ b_in;
      default: w_alu = '0;
    endcase
  end

  // MUL step: conditionally add multiplicand to upper word, then shift the
  // {carry, hi, lo} chain right by one; the product ends up in {hi, lo}.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
  assign w_mhi = w_sum[32:1];
  assign w_mlo = {w_sum[0], r_lo[31:1]};

  // DIV step: shift next dividend bit into the remainder, subtract when it
  // fits. A zero divisor always fits, which naturally yields an all-ones
  // quotient and remainder = a.
  assign w_rsh  = {r_hi, r_lo[31]};
  assign w_ge   = w_rsh >= {1'b0, r_a};
  assign w_rsub = w_rsh[31:0] - r_a;
  assign w_dhi  = w_ge ? w_rsub : w_rsh[31:0];
  assign w_dlo  = {r_lo[30:0], w_ge};

  assign w_last = (r_cnt == 5'd31);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start_in && alu_ctrl_in == 4'b0010) w_state_nxt = MUL_IT;
        else if (start_in && alu_ctrl_in == 4'b0011) w_state_nxt = DIV_IT;
      end
      MUL_IT, DIV_IT: if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_cnt <= '0;
            r_hi  <= '0;
            if (alu_ctrl_in == 4'b0010) begin
              r_a  <= a_in;
              r_lo <= b_in;
            end else if (alu_ctrl_in == 4'b0011) begin
              r_a  <= b_in;
              r_lo <= a_in;
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
              r_div0   <= 1'b0;
              r_done   <= 1'b1;
            end
          end
        end
        MUL_IT: begin
          r_hi  <= w_mhi;
          r_lo  <= w_mlo;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_result <= w_mlo;
            r_zero   <= (w_mlo == '0);
            r_div0   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        DIV_IT: begin
          r_hi  <= w_dhi;
          r_lo  <= w_dlo;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_result <= w_dlo;
            r_zero   <= (w_dlo == '0);
            r_div0   <= (r_a == '0);
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_HI_LO_EN
  logic [31:0] r_hi_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_out <= '0;
    end else begin
      case (r_state)
        IDLE:    if (start_in && alu_ctrl_in != 4'b0010 && alu_ctrl_in != 4'b0011)
                   r_hi_out <= '0;
        MUL_IT:  if (w_last) r_hi_out <= w_mhi;
        DIV_IT:  if (w_last) r_hi_out <= w_dhi;
        default: ;
      endcase
    end
  end

  assign hi_out = r_hi_out;
`else
  assign hi_out = '0;
`endif

  assign result_out = r_result;
  assign zero_out   = r_zero;
  assign busy_out   = (r_state != IDLE);
  assign done_out   = r_done;
  assign div0_out   = r_div0;

endmodule
